// File: rtl/clint_timer_pkg.sv
// -----------------------------------------------------------------------------
// clint_timer_pkg
// Shared configuration and register-map constants for the core-local
// interruptor (CLINT): bus window, RTC divider, register offsets, the
// mtimecmp reset value and a byte-enable merge helper.
// -----------------------------------------------------------------------------
package clint_timer_pkg;

  // Bus window occupied by the CLINT on the data-side memory bus.
  localparam logic [31:0] clint_base_addr = 32'h0200_0000;
  localparam logic [31:0] clint_span      = 32'h0000_FFFF;
  localparam logic [31:0] clint_top_addr  = clint_base_addr + clint_span;

  // RTC half-period in core clocks, minus one.
  localparam int unsigned clk_divider_rtc = 4;

  // Register offsets relative to the window base.
  localparam logic [31:0] clint_msip_off     = 32'h0000_0000;
  localparam logic [31:0] clint_mtimecmp_off = 32'h0000_4000;
  localparam logic [31:0] clint_mtime_off    = 32'h0000_BFF8;

  // mtimecmp powers up at the maximum so no timer interrupt fires after reset.
  localparam logic [63:0] clint_mtimecmp_rst = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace only the byte lanes selected by wstrb.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] mask;
    mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    return (old_val & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/clint_rtc_tick.sv
// -----------------------------------------------------------------------------
// clint_rtc_tick
// Divides the core clock down to the RTC. A counter runs 0..div and toggles
// the RTC phase on wrap; tick pulses for one cycle on every 0->1 phase
// transition, giving one tick every 2*(div+1) core clocks.
//
// Ports:
//   clock  in   core clock
//   reset  in   asynchronous active-low reset
//   tick   out  one-cycle pulse per RTC period (registered)
// -----------------------------------------------------------------------------
module clint_rtc_tick
  import clint_timer_pkg::*;
#(
  parameter int unsigned div = clk_divider_rtc
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned cnt_w = (div < 1) ? 1 : $clog2(div + 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(div);

  logic [cnt_w-1:0] count_q, count_d;
  logic             phase_q, phase_d;
  logic             tick_q, tick_d;
  logic             wrap;

  assign wrap = (count_q == cnt_last);

  // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    count_d = wrap ? '0 : count_q + cnt_w'(1);
    phase_d = wrap ? ~phase_q : phase_q;
    // The pulse coincides with the phase becoming 1.
    tick_d  = wrap & ~phase_q;
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
// Core-local interruptor on the data-side memory bus. Holds the 64-bit mtime
// counter (advanced by the RTC tick), 64-bit mtimecmp and the msip bit, and
// drives the machine timer/software interrupt lines plus mtime to the CSRs.
// Every request is answered exactly one cycle later; writes take effect at the
// edge that samples mem_valid. Unmapped offsets read 0 and ignore writes.
//
// Build option: define CLINT_MTIME_WRITE_EN to make mtime writable at
// 0xBFF8/0xBFFC (a write beats a same-cycle tick). Undefined: mtime is
// read-only and writes to it are acknowledged but dropped.
//
// Ports:
//   clock        in   core clock
//   reset        in   asynchronous active-low reset
//   mem_valid    in   single-cycle request strobe
//   mem_addr     in   word-aligned byte address
//   mem_wdata    in   write data
//   mem_wstrb    in   byte enables, nonzero = write, zero = read
//   mem_rdata    out  read data, zero except while mem_ready is high
//   mem_ready    out  response strobe, one cycle after mem_valid
//   clint_msip   out  machine software interrupt pending
//   clint_mtip   out  machine timer interrupt pending
//   clint_mtime  out  current mtime
// -----------------------------------------------------------------------------
module clint_timer #(
  parameter logic [31:0] clint_base_addr = clint_timer_pkg::clint_base_addr,
  parameter int unsigned clk_divider_rtc = clint_timer_pkg::clk_divider_rtc
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        clint_msip,
  output logic        clint_mtip,
  output logic [63:0] clint_mtime
);

  import clint_timer_pkg::*;

  localparam logic [31:0] top_addr       = clint_base_addr + clint_span;
  localparam logic [31:0] mtimecmp_hi_off = clint_mtimecmp_off + 32'd4;
  localparam logic [31:0] mtime_hi_off    = clint_mtime_off + 32'd4;

  logic        tick;
  logic [31:0] offset;
  logic        hit;
  logic        is_write;

  logic        msip_q, msip_d;
  logic        mtip_q, mtip_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;

  clint_rtc_tick #(
    .div (clk_divider_rtc)
  ) u_rtc_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign offset   = mem_addr - clint_base_addr;
  assign hit      = (mem_addr >= clint_base_addr) && (mem_addr <= top_addr);
  assign is_write = |mem_wstrb;

  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    rdata_d    = '0;
    ready_d    = mem_valid;

    if (mem_valid && hit) begin
      if (is_write) begin
        case (offset)
          clint_msip_off:     if (mem_wstrb[0]) msip_d = mem_wdata[0];
          clint_mtimecmp_off: mtimecmp_d[31:0]  = apply_wstrb(mtimecmp_q[31:0], mem_wdata, mem_wstrb);
          mtimecmp_hi_off:    mtimecmp_d[63:32] = apply_wstrb(mtimecmp_q[63:32], mem_wdata, mem_wstrb);
`ifdef CLINT_MTIME_WRITE_EN
          // Built from mtime_q, so a coincident tick is dropped entirely.
          clint_mtime_off:    mtime_d = {mtime_q[63:32], apply_wstrb(mtime_q[31:0], mem_wdata, mem_wstrb)};
          mtime_hi_off:       mtime_d = {apply_wstrb(mtime_q[63:32], mem_wdata, mem_wstrb), mtime_q[31:0]};
`endif
          default: ;
        endcase
      end else begin
        // Reads see the pre-tick mtime.
        case (offset)
          clint_msip_off:     rdata_d = {31'b0, msip_q};
          clint_mtimecmp_off: rdata_d = mtimecmp_q[31:0];
          mtimecmp_hi_off:    rdata_d = mtimecmp_q[63:32];
          clint_mtime_off:    rdata_d = mtime_q[31:0];
          mtime_hi_off:       rdata_d = mtime_q[63:32];
          default:            rdata_d = '0;
        endcase
      end
    end

    // Compare the values the registers will hold after this edge.
    mtip_d = (mtime_d >= mtimecmp_d);
  end

  // NOTE: every CLINT register is a plain flop with a defined reset value; there is no array to leave unreset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= clint_mtimecmp_rst;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
    end
  end

  assign mem_rdata   = rdata_q;
  assign mem_ready   = ready_q;
  assign clint_msip  = msip_q;
  assign clint_mtip  = mtip_q;
  assign clint_mtime = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// -----------------------------------------------------------------------------
// tb_clint_timer
// Self-checking bench for clint_timer. A behavioural model tracks mtime from
// the number of clock edges since reset, plus the register file and bus
// response; a compare process checks all outputs against it every cycle.
// Directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_clint_timer;

  localparam logic [31:0] base        = 32'h0200_0000;
  localparam int unsigned tick_period = 10;  // 2*(4+1) core clocks
  localparam int unsigned first_tick  = 6;   // edge number of the first mtime increment

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr  = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        clint_msip;
  logic        clint_mtip;
  logic [63:0] clint_mtime;

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  clint_timer dut (
    .clock       (clock),
    .reset       (reset),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .clint_msip  (clint_msip),
    .clint_mtip  (clint_mtip),
    .clint_mtime (clint_mtime)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++)
      if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  int unsigned edge_n;
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_mtip, m_ready;
  logic [31:0] m_rdata;

  always @(posedge clock or negedge reset) begin : model
    logic [31:0] off;
    logic [63:0] nt;
    if (!reset) begin
      edge_n  = 0;
      m_mtime = '0;
      m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
      m_msip  = 1'b0;
      m_mtip  = 1'b0;
      m_ready = 1'b0;
      m_rdata = '0;
    end else begin
      edge_n++;
      nt = m_mtime + (((edge_n % tick_period) == first_tick) ? 64'd1 : 64'd0);
      m_ready = mem_valid;
      m_rdata = '0;
      if (mem_valid) begin
        off = mem_addr - base;
        if (mem_wstrb == 4'h0) begin
          case (off)
            32'h0000: m_rdata = {31'b0, m_msip};
            32'h4000: m_rdata = m_cmp[31:0];
            32'h4004: m_rdata = m_cmp[63:32];
            32'hBFF8: m_rdata = m_mtime[31:0];
            32'hBFFC: m_rdata = m_mtime[63:32];
            default:  m_rdata = '0;
          endcase
        end else begin
          case (off)
            32'h0000: if (mem_wstrb[0]) m_msip = mem_wdata[0];
            32'h4000: m_cmp[31:0]  = merge(m_cmp[31:0], mem_wdata, mem_wstrb);
            32'h4004: m_cmp[63:32] = merge(m_cmp[63:32], mem_wdata, mem_wstrb);
`ifdef CLINT_MTIME_WRITE_EN
            32'hBFF8: nt = {m_mtime[63:32], merge(m_mtime[31:0], mem_wdata, mem_wstrb)};
            32'hBFFC: nt = {merge(m_mtime[63:32], mem_wdata, mem_wstrb), m_mtime[31:0]};
`endif
            default: ;
          endcase
        end
      end
      m_mtime = nt;
      m_mtip  = (m_mtime >= m_cmp);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    check("mem_ready", mem_ready, m_ready);
    check("mem_rdata", mem_rdata, m_rdata);
    check("msip", clint_msip, m_msip);
    check("mtip", clint_mtip, m_mtip);
    check("mtime", clint_mtime, m_mtime);
  end

  // ---------------- directed stimulus ----------------
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    @(negedge clock);
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_mtime", clint_mtime, 64'd0);
    check("reset_ready", mem_ready, 1'b0);
    reset = 1'b1;

    // Free-running RTC: first increment at edge 6, then every 10 edges.
    repeat (5) @(negedge clock);
    check("pre_tick_mtime", clint_mtime, 64'd0);
    @(negedge clock);
    check("first_tick_mtime", clint_mtime, 64'd1);
    repeat (94) @(negedge clock);
    check("mtime_at_100", clint_mtime, 64'd10);
    check("mtip_at_100", clint_mtip, 1'b0);
    check("msip_at_100", clint_msip, 1'b0);

    // msip write / read / clear, and a strobe missing byte 0.
    bus(base, 32'h1, 4'hF);
    check("msip_set", clint_msip, 1'b1);
    check("wr_ready", mem_ready, 1'b1);
    check("wr_rdata", mem_rdata, 32'h0);
    bus(base, 32'h0, 4'h0);
    check("msip_read", mem_rdata, 32'h1);
    bus(base, 32'h0, 4'hF);
    check("msip_clear", clint_msip, 1'b0);
    bus(base, 32'h1, 4'b0010);
    check("msip_strobe", clint_msip, 1'b0);

    // Unmapped offsets.
    bus(base + 32'h10, 32'h0, 4'h0);
    check("unmap_rd_ready", mem_ready, 1'b1);
    check("unmap_rd_rdata", mem_rdata, 32'h0);
    bus(base + 32'h8000, 32'hFFFF_FFFF, 4'hF);
    check("unmap_wr_ready", mem_ready, 1'b1);
    @(negedge clock);
    check("idle_ready", mem_ready, 1'b0);

    // Back-to-back: mtime lo, mtime hi, msip.
    mem_valid = 1'b1;
    mem_wstrb = 4'h0;
    mem_addr  = base + 32'hBFF8;
    @(negedge clock);
    check("b2b_ready0", mem_ready, 1'b1);
    mem_addr = base + 32'hBFFC;
    @(negedge clock);
    check("b2b_ready1", mem_ready, 1'b1);
    check("b2b_mtime_hi", mem_rdata, 32'h0);
    mem_addr = base;
    @(negedge clock);
    check("b2b_ready2", mem_ready, 1'b1);
    check("b2b_msip", mem_rdata, 32'h0);
    mem_valid = 1'b0;
    mem_addr  = '0;
    @(negedge clock);
    check("b2b_done", mem_ready, 1'b0);

    // Reset while a response is pending.
    mem_valid = 1'b1;
    mem_addr  = base;
    @(posedge clock);
    #1 reset = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    #1 check("rst_mid_ready", mem_ready, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // mtimecmp = 5: mtip rises with mtime reaching 5 (edge 46 after reset).
    bus(base + 32'h4000, 32'd5, 4'hF);
    bus(base + 32'h4004, 32'd0, 4'hF);
    check("cmp_mtip_low", clint_mtip, 1'b0);
    begin
      int n = 0;
      while (clint_mtime != 64'd5 && n < 100) begin
        @(negedge clock);
        n++;
      end
      check("cmp_wait_bound", (n < 100) ? 1'b1 : 1'b0, 1'b1);
      check("cmp_wait_edges", 64'(edge_n), 64'd46);
    end
    check("mtip_rise", clint_mtip, 1'b1);
    bus(base + 32'h4000, 32'd1000, 4'hF);
    check("mtip_clear", clint_mtip, 1'b0);

`ifdef CLINT_MTIME_WRITE_EN
    bus(base + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    bus(base + 32'hBFFC, 32'h0, 4'hF);
    begin
      int n = 0;
      while (clint_mtime == 64'h0000_0000_FFFF_FFFF && n < 30) begin
        @(negedge clock);
        n++;
      end
      check("wrap_bound", (n < 30) ? 1'b1 : 1'b0, 1'b1);
    end
    check("mtime_carry", clint_mtime, 64'h1_0000_0000);
    begin
      int n = 0;
      while ((edge_n % tick_period) != (first_tick - 1) && n < 30) begin
        @(negedge clock);
        n++;
      end
      check("align_bound", (n < 30) ? 1'b1 : 1'b0, 1'b1);
    end
    bus(base + 32'hBFF8, 32'h0000_1234, 4'hF);
    check("write_beats_tick", clint_mtime, 64'h1_0000_1234);
`else
    bus(base + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    check("ro_mtime_ready", mem_ready, 1'b1);
    check("ro_mtime_rdata", mem_rdata, 32'h0);
    check("ro_mtime_val", clint_mtime[31:0] == 32'hFFFF_FFFF ? 1'b1 : 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
